// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// default widths and the opcode field position.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_HI      = 15;
  localparam int OPC_LO      = 12;
  localparam logic [OPC_HI-OPC_LO:0] HALT_OPCODE_DEF = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    VALID   = 3'd3,
    HALTED  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/iram_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, absorbs the one-cycle IRAM read
// latency and hands instructions to the control unit over valid/ready.
module iram_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                          ADDR_W      = ADDR_W_DEF,
  parameter int                          INSTR_W     = INSTR_W_DEF,
  parameter logic [OPC_HI-OPC_LO:0]      HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [ADDR_W-1:0]           RESET_PC    = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  iram_addr,
  input  logic [INSTR_W-1:0] iram_q,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        retired_cnt
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign iram_addr = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      busy        <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          // The IRAM samples pc at this edge; a redirect simply re-issues.
          if (redirect) begin
            pc    <= redirect_addr;
            state <= ISSUE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (redirect) begin
            pc    <= redirect_addr;
            state <= ISSUE;
          end else begin
            instr       <= iram_q;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          // Redirect wins over acceptance: the held instruction is dropped.
          if (redirect) begin
            pc          <= redirect_addr;
            instr_valid <= 1'b0;
            state       <= ISSUE;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            retired_cnt <= sat_inc(retired_cnt);
            if (instr[OPC_HI:OPC_LO] == HALT_OPCODE) begin
              halted <= 1'b1;
              busy   <= 1'b0;
              state  <= HALTED;
            end else begin
              pc    <= pc + ADDR_W'(1);
              state <= ISSUE;
            end
          end
        end
        HALTED: begin
          if (start) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
